// File: rtl/inst_sequencer.sv
// Attention-pass instruction sequencer: walks K load, QK exec, norm, V load, MAC2, store and readout phases.
// Registered outputs, one word per cycle from the cycle after the start edge; no backpressure, start ignored while busy.
module inst_sequencer #(
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_cyc     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  phase
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    KLOAD   = 4'd1,
    GAP1    = 4'd2,
    EXEC    = 4'd3,
    GAP2    = 4'd4,
    NORM    = 4'd5,
    VLOAD   = 4'd6,
    GAP3    = 4'd7,
    MAC2    = 4'd8,
    GAP4    = 4'd9,
    STORE   = 4'd10,
    READOUT = 4'd11,
    DONE    = 4'd12
  } state_t;

  // Final in-state count for each phase.
  localparam logic [15:0] L_LOAD  = 16'(col + 2);
  localparam logic [15:0] LOAD_HI = 16'(col + 1);
  localparam logic [15:0] L_GAP   = 16'(gap_cyc - 1);
  localparam logic [15:0] L_TC    = 16'(total_cycle - 1);
  localparam logic [15:0] L_NORM  = 16'(4 * total_cycle - 1);
  localparam logic [15:0] L_STORE = 16'(2 * total_cycle - 1);
  localparam logic [15:0] L_READ  = 16'(total_cycle);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_inst;
  logic        r_busy;
  logic        r_done;

  state_t      w_nxt_state;
  logic [15:0] w_nxt_cnt;
  logic [15:0] w_last;

  function automatic logic [31:0] word_of(input state_t s, input logic [15:0] c);
    logic [31:0] w;
    logic [15:0] i;
    w = '0;
    i = '0;
    case (s)
      KLOAD, VLOAD: begin
        if (s == KLOAD) w[6] = 1'b1;
        else            w[27] = 1'b1;
        if (c >= 16'd1 && c <= LOAD_HI) begin
          if (s == KLOAD) w[3] = 1'b1;
          else            w[22] = 1'b1;
        end
        // Address lags the read by one so the array sees row c-1 on load.
        if (c >= 16'd2 && c <= LOAD_HI) w[15:12] = c[3:0] - 4'd1;
      end
      EXEC: begin
        w[7]     = 1'b1;
        w[5]     = 1'b1;
        w[15:12] = c[3:0];
      end
      NORM: begin
        i        = c >> 2;
        w[11:8]  = i[3:0];
        case (c[1:0])
          2'd0:    w[16] = (i != 16'd0);
          2'd1:    w[18] = 1'b1;
          2'd2:    begin w[19] = 1'b1; w[20] = 1'b1; end
          default: w[0] = 1'b1;
        endcase
      end
      MAC2: begin
        w[28]   = 1'b1;
        w[1]    = 1'b1;
        w[11:8] = c[3:0];
      end
      STORE: begin
        i       = c >> 1;
        w[11:8] = i[3:0];
        if (!c[0]) w[29] = (i != 16'd0);
        else       w[30] = 1'b1;
      end
      READOUT: begin
        w[31]   = 1'b1;
        w[11:8] = c[3:0];
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    w_last = '0;
    case (r_state)
      KLOAD, VLOAD:            w_last = L_LOAD;
      GAP1, GAP2, GAP3, GAP4:  w_last = L_GAP;
      EXEC, MAC2:              w_last = L_TC;
      NORM:                    w_last = L_NORM;
      STORE:                   w_last = L_STORE;
      READOUT:                 w_last = L_READ;
      default:                 w_last = '0;
    endcase
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 16'd1;
    if (r_state == IDLE) begin
      w_nxt_cnt = '0;
      if (start) w_nxt_state = KLOAD;
    end else if (r_cnt == w_last) begin
      w_nxt_cnt   = '0;
      w_nxt_state = (r_state == DONE) ? IDLE : state_t'(r_state + 4'd1);
    end
  end

  // Outputs are computed from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_inst  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_inst  <= word_of(w_nxt_state, w_nxt_cnt);
      r_busy  <= (w_nxt_state != IDLE) && (w_nxt_state != DONE);
      r_done  <= (w_nxt_state == DONE);
    end
  end

  assign inst  = r_inst;
  assign busy  = r_busy;
  assign done  = r_done;
  assign phase = r_state;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: cycle-stamped expectations, negedge monitor.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  phase;

  always #5 clk = ~clk;

  inst_sequencer #(.col(8), .total_cycle(8), .gap_cyc(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .inst(inst), .busy(busy), .done(done), .phase(phase)
  );

  typedef struct {
    int          cyc;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  phase;
    logic [79:0] name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   base;
  int   bk;

  logic [31:0] p_inst [1:136];
  logic        p_busy [1:136];
  logic        p_done [1:136];
  logic [3:0]  p_ph   [1:136];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic put(input logic [31:0] w, input logic [3:0] ph, input logic b, input logic d);
    p_inst[bk] = w; p_ph[bk] = ph; p_busy[bk] = b; p_done[bk] = d;
    bk = bk + 1;
  endtask

  // Expected words for a default-parameter pass, cycle 1..136 after the start edge.
  task automatic build_pass();
    logic [31:0] w;
    logic [31:0] a;
    bk = 1;
    for (int c = 0; c < 11; c++) begin
      w = 32'h40;
      if (c >= 1 && c <= 9) w = w | 32'h8;
      if (c >= 2 && c <= 9) w = w | (32'(c - 1) << 12);
      put(w, 4'd1, 1'b1, 1'b0);
    end
    for (int c = 0; c < 10; c++) put(32'h0, 4'd2, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++)  put(32'hA0 | (32'(c) << 12), 4'd3, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) put(32'h0, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 32'(i) << 8;
      put(((i != 0) ? 32'h10000 : 32'h0) | a, 4'd5, 1'b1, 1'b0);
      put(32'h40000 | a, 4'd5, 1'b1, 1'b0);
      put(32'h180000 | a, 4'd5, 1'b1, 1'b0);
      put(32'h1 | a, 4'd5, 1'b1, 1'b0);
    end
    for (int c = 0; c < 11; c++) begin
      w = 32'h0800_0000;
      if (c >= 1 && c <= 9) w = w | 32'h0040_0000;
      if (c >= 2 && c <= 9) w = w | (32'(c - 1) << 12);
      put(w, 4'd6, 1'b1, 1'b0);
    end
    for (int c = 0; c < 10; c++) put(32'h0, 4'd7, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++)  put(32'h1000_0002 | (32'(c) << 8), 4'd8, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) put(32'h0, 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 32'(i) << 8;
      put(((i != 0) ? 32'h2000_0000 : 32'h0) | a, 4'd10, 1'b1, 1'b0);
      put(32'h4000_0000 | a, 4'd10, 1'b1, 1'b0);
    end
    for (int c = 0; c < 9; c++) put(32'h8000_0000 | (32'(c) << 8), 4'd11, 1'b1, 1'b0);
    put(32'h0, 4'd12, 1'b0, 1'b1);
  endtask

  task automatic want(input int c, input logic [31:0] w, input logic b, input logic d,
                      input logic [3:0] ph, input logic [79:0] nm);
    exp_t e;
    e.cyc = c; e.inst = w; e.busy = b; e.done = d; e.phase = ph; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic want_idle(input int c, input logic [79:0] nm);
    want(c, 32'h0, 1'b0, 1'b0, 4'd0, nm);
  endtask

  task automatic push_pass(input int b, input int upto, input bit spots);
    for (int k = 1; k <= upto; k++) want(b + k, p_inst[k], p_busy[k], p_done[k], p_ph[k], "pass");
    if (spots) begin
      if (upto >= 3) begin
        want(b + 1, 32'h0000_0040, 1'b1, 1'b0, 4'd1, "kload_c1");
        want(b + 2, 32'h0000_0048, 1'b1, 1'b0, 4'd1, "kload_c2");
        want(b + 3, 32'h0000_1048, 1'b1, 1'b0, 4'd1, "kload_c3");
      end
      if (upto >= 39) begin
        want(b + 22, 32'h0000_00A0, 1'b1, 1'b0, 4'd3, "exec_c0");
        want(b + 29, 32'h0000_70A0, 1'b1, 1'b0, 4'd3, "exec_c7");
        want(b + 30, 32'h0, 1'b1, 1'b0, 4'd4, "gap2_first");
        want(b + 39, 32'h0, 1'b1, 1'b0, 4'd4, "gap2_last");
      end
      if (upto >= 55) begin
        want(b + 40, 32'h0, 1'b1, 1'b0, 4'd5, "norm_i0s0");
        want(b + 52, 32'h0001_0300, 1'b1, 1'b0, 4'd5, "norm_i3s0");
        want(b + 54, 32'h0018_0300, 1'b1, 1'b0, 4'd5, "norm_i3s2");
        want(b + 55, 32'h0000_0301, 1'b1, 1'b0, 4'd5, "norm_i3s3");
      end
      if (upto >= 136) begin
        want(b + 135, 32'h8000_0800, 1'b1, 1'b0, 4'd11, "rd_last");
        want(b + 136, 32'h0, 1'b0, 1'b1, 4'd12, "done");
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  initial begin : mon
    int idx;
    forever begin
      @(negedge clk);
      idx = 0;
      while (idx < sb.size()) begin
        if (sb[idx].cyc == cyc) begin
          total++;
          if ({inst, busy, done, phase} !== {sb[idx].inst, sb[idx].busy, sb[idx].done, sb[idx].phase}) begin
            bad++;
            $display("FAIL %s cyc=%0d got inst=%h busy=%b done=%b phase=%0d want inst=%h busy=%b done=%b phase=%0d",
                     sb[idx].name, cyc, inst, busy, done, phase,
                     sb[idx].inst, sb[idx].busy, sb[idx].done, sb[idx].phase);
          end
          sb.delete(idx);
        end else if (sb[idx].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL %s missed check for cyc=%0d (now %0d)", sb[idx].name, sb[idx].cyc, cyc);
          sb.delete(idx);
        end else begin
          idx++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    build_pass();
    tick(); tick();
    want_idle(cyc, "rst_a");
    start = 1'b1;
    tick();
    want_idle(cyc, "rst_start");

    // Single pulse on the first edge after reset release.
    reset = 1'b1;
    base = cyc;
    push_pass(base, 136, 1'b1);
    want_idle(base + 137, "idle1");
    tick(); start = 1'b0;
    goto(base + 138);

    // Re-pulses while busy and in DONE are ignored.
    start = 1'b1;
    base = cyc;
    push_pass(base, 136, 1'b1);
    want_idle(base + 137, "idle2a");
    want_idle(base + 138, "idle2b");
    tick(); start = 1'b0;
    goto(base + 5);   start = 1'b1; tick(); start = 1'b0;
    goto(base + 100); start = 1'b1; tick(); start = 1'b0;
    goto(base + 136); start = 1'b1; tick(); start = 1'b0;
    goto(base + 139);

    // Reset mid-NORM, then a clean restart.
    start = 1'b1;
    base = cyc;
    push_pass(base, 60, 1'b1);
    want_idle(base + 61, "midrst_a");
    want_idle(base + 62, "midrst_b");
    tick(); start = 1'b0;
    goto(base + 60);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    start = 1'b1;
    base = cyc;
    push_pass(base, 136, 1'b1);
    want_idle(base + 137, "idle3");
    tick(); start = 1'b0;
    goto(base + 138);

    // Start held high: back-to-back passes with one IDLE cycle after DONE.
    start = 1'b1;
    base = cyc;
    push_pass(base, 136, 1'b0);
    want_idle(base + 137, "held_gap");
    push_pass(base + 137, 136, 1'b0);
    want(base + 138, 32'h0000_0040, 1'b1, 1'b0, 4'd1, "held_p2c1");
    goto(base + 138);
    start = 1'b0;
    want_idle(base + 274, "held_end");
    goto(base + 276);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
